hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl.sv | 54 +++++
 tb/tb_hilo_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file with multi-cycle multiply sequencing and pipeline stall
module hilo_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mult_z,
  input  logic [63:0] multu_z,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       sgn;
  assign busy    = state == RUN;
  assign stall   = busy & (op_valid | mf_req);
  assign rd_data = mf_sel ? hi : lo;
  // Accept ops only in IDLE; count the multiply down in RUN, then commit the selected product
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sgn   <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == IDLE) begin
      if (op_valid && !op[1]) begin
        mul_a <= rs_data;
        mul_b <= rt_data;
        sgn   <= ~op[0];
        cnt   <= 4'(MUL_LAT - 1);
        state <= RUN;
      end else if (op_valid && op[0]) lo <= rs_data;
      else if (op_valid) hi <= rs_data;
    end else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    else begin
      {hi, lo} <= sgn ? mult_z : multu_z;
      state    <= IDLE;
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed self-checking bench for hilo_ctrl with MUL_LAT=4
module tb_hilo_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        mf_req = 1'b0;
  logic        mf_sel = 1'b0;
  logic [31:0] rd_data, mul_a, mul_b, hi, lo;
  logic        stall, busy;
  logic [63:0] mult_z = '0;
  logic [63:0] multu_z = '0;
  int n_cmp = 0;
  int n_fail = 0;

  hilo_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .mf_req(mf_req), .mf_sel(mf_sel), .rd_data(rd_data),
    .stall(stall), .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mult_z(mult_z),
    .multu_z(multu_z), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    op_valid = 1'b1; op = 2'b00; rs_data = 32'd1; rt_data = 32'd2; mf_req = 1'b1; mf_sel = 1'b1;
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", stall); end
    n_cmp++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd got %h exp 0", rd_data); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rst_hilo got %h exp 0", {hi, lo}); end
    n_cmp++; if ({mul_a, mul_b} !== 64'h0) begin n_fail++; $display("FAIL rst_mul got %h exp 0", {mul_a, mul_b}); end
    op = 2'b10; rs_data = 32'hA5A5A5A5; mf_req = 1'b0;
    #2 reset = 1'b1;
    tick;
    op_valid = 1'b0;
    n_cmp++; if (hi !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL first_accept_hi got %h exp a5a5a5a5", hi); end
    n_cmp++; if (busy !== 1'b0 || lo !== 32'h0) begin n_fail++; $display("FAIL first_accept_other got busy=%b lo=%h exp 0/0", busy, lo); end
  endtask

  task automatic test_mult_stall;
    op_valid = 1'b1; op = 2'b00; rs_data = 32'hFFFFFFFD; rt_data = 32'h00000005;
    mult_z = 64'hFFFFFFFF_FFFFFFF1; multu_z = 64'h12345678_9ABCDEF0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall got %b exp 0", stall); end
    tick;
    op_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy0 got %b exp 1", busy); end
    n_cmp++; if ({mul_a, mul_b} !== 64'hFFFFFFFD_00000005) begin n_fail++; $display("FAIL mult_ops got %h exp fffffffd00000005", {mul_a, mul_b}); end
    tick;
    mf_req = 1'b1; mf_sel = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (stall !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mf_stall%0d got stall=%b busy=%b exp 1/1", i, stall, busy); end
      n_cmp++; if (rd_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mf_old%0d got %h exp a5a5a5a5", i, rd_data); end
      tick;
    end
    n_cmp++; if (stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mf_release got stall=%b busy=%b exp 0/0", stall, busy); end
    n_cmp++; if (rd_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mf_newhi got %h exp ffffffff", rd_data); end
    n_cmp++; if (lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo got %h exp fffffff1", lo); end
    mf_req = 1'b0;
  endtask

  task automatic test_multu_reject;
    int n;
    op_valid = 1'b1; op = 2'b01; rs_data = 32'hFFFFFFFF; rt_data = 32'h00000002;
    multu_z = 64'h00000001_FFFFFFFE; mult_z = 64'hDEADBEEF_CAFEF00D;
    tick;
    op = 2'b11; rs_data = 32'h00000BAD;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reject_stall got %b exp 1", stall); end
    tick;
    n_cmp++; if (lo !== 32'hFFFFFFF1 || mul_a !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reject_hold got lo=%h mul_a=%h exp fffffff1/ffffffff", lo, mul_a); end
    op_valid = 1'b0;
    n = 1;
    while (busy && n < 20) begin n++; tick; end
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL multu_busy_len got %0d exp 4", n); end
    n_cmp++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin n_fail++; $display("FAIL multu_hilo got %h exp 00000001fffffffe", {hi, lo}); end
  endtask

  task automatic test_mtlo_mf;
    op_valid = 1'b1; op = 2'b11; rs_data = 32'h00001234;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall got %b exp 0", stall); end
    tick;
    op_valid = 1'b0; mf_req = 1'b1; mf_sel = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 32'h00001234) begin n_fail++; $display("FAIL mflo got %h exp 00001234", rd_data); end
    n_cmp++; if (hi !== 32'h00000001 || stall !== 1'b0) begin n_fail++; $display("FAIL mtlo_side got hi=%h stall=%b exp 00000001/0", hi, stall); end
    op_valid = 1'b1; op = 2'b10; rs_data = 32'h00000055; mf_sel = 1'b1;
    #1;
    n_cmp++; if (rd_data !== 32'h00000001) begin n_fail++; $display("FAIL simul_old got %h exp 00000001", rd_data); end
    tick;
    n_cmp++; if (rd_data !== 32'h00000055 || lo !== 32'h00001234) begin n_fail++; $display("FAIL simul_new got hi=%h lo=%h exp 00000055/00001234", rd_data, lo); end
    op_valid = 1'b0; mf_req = 1'b0;
  endtask

  task automatic test_reset_abort;
    op_valid = 1'b1; op = 2'b00; rs_data = 32'h7; rt_data = 32'h9; mult_z = 64'h11112222_33334444;
    tick;
    op_valid = 1'b0;
    tick;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({hi, lo} !== 64'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_now got hilo=%h busy=%b exp 0/0", {hi, lo}, busy); end
    n_cmp++; if ({mul_a, mul_b} !== 64'h0) begin n_fail++; $display("FAIL abort_mul got %h exp 0", {mul_a, mul_b}); end
    #2 reset = 1'b1;
    repeat (4) tick;
    n_cmp++; if ({hi, lo} !== 64'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_late got hilo=%h busy=%b exp 0/0", {hi, lo}, busy); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_busy;
    exp_busy = 10'b0_1111_0_1111;
    op_valid = 1'b1; op = 2'b00; rs_data = 32'h3; rt_data = 32'h4; mult_z = 64'h0000000C;
    tick;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) op_valid = 1'b0;
      #1;
      n_cmp++; if (busy !== exp_busy[i]) begin n_fail++; $display("FAIL b2b_busy%0d got %b exp %b", i, busy, exp_busy[i]); end
      n_cmp++; if (stall !== (exp_busy[i] & (i < 5))) begin n_fail++; $display("FAIL b2b_stall%0d got %b exp %b", i, stall, exp_busy[i] & (i < 5)); end
      tick;
    end
    n_cmp++; if ({hi, lo} !== 64'h0000000C) begin n_fail++; $display("FAIL b2b_hilo got %h exp 000000000000000c", {hi, lo}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    test_reset;
    test_mult_stall;
    test_multu_reject;
    test_mtlo_mf;
    test_reset_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
